// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: direct-mapped instruction cache in front of a
// valid/ready program-memory read port, returning one instruction per request.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_ENTRIES         = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_start,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_done,
  output logic                             busy,
  output logic                             cache_hit
);

  localparam int IDX_BITS = $clog2(CACHE_ENTRIES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, REQUEST, DONE} state_t;

  state_t                             state_q, state_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction_q, instruction_d;
  logic                               cache_hit_q, cache_hit_d;
  logic                               mem_read_valid_q, mem_read_valid_d;
  logic                               fetch_done_q, fetch_done_d;
  logic                               busy_q, busy_d;
  logic [CACHE_ENTRIES-1:0]           valid_q, valid_d;

  logic [TAG_BITS-1:0]                tag_q  [CACHE_ENTRIES];
  logic [PROGRAM_MEM_DATA_BITS-1:0]   data_q [CACHE_ENTRIES];

  logic [IDX_BITS-1:0]                line_idx;
  logic [TAG_BITS-1:0]                line_tag;
  logic                               line_hit;
  logic                               fill_en;

  assign line_idx = addr_q[IDX_BITS-1:0];
  assign line_tag = addr_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

  // A flush on the lookup edge must not let a soon-to-be-invalid line answer.
  assign line_hit = valid_q[line_idx] && (tag_q[line_idx] == line_tag) && !flush;
  assign fill_en  = (state_q == REQUEST) && mem_read_ready && !flush;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    instruction_d = instruction_q;
    cache_hit_d   = cache_hit_q;
    valid_d       = valid_q;

    if (fill_en) valid_d[line_idx] = 1'b1;
    if (flush)   valid_d = '0;

    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          addr_d  = pc;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (line_hit) begin
          instruction_d = data_q[line_idx];
          cache_hit_d   = 1'b1;
          state_d       = DONE;
        end else begin
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (mem_read_ready) begin
          instruction_d = mem_read_data;
          cache_hit_d   = 1'b0;
          state_d       = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave a flop directly.
    mem_read_valid_d = (state_d == REQUEST);
    fetch_done_d     = (state_d == DONE);
    busy_d           = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      instruction_q    <= '0;
      cache_hit_q      <= 1'b0;
      mem_read_valid_q <= 1'b0;
      fetch_done_q     <= 1'b0;
      busy_q           <= 1'b0;
      valid_q          <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      instruction_q    <= instruction_d;
      cache_hit_q      <= cache_hit_d;
      mem_read_valid_q <= mem_read_valid_d;
      fetch_done_q     <= fetch_done_d;
      busy_q           <= busy_d;
      valid_q          <= valid_d;
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone guard its contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= mem_read_data;
    end
  end

  assign mem_read_valid   = mem_read_valid_q;
  assign mem_read_address = addr_q;
  assign instruction      = instruction_q;
  assign fetch_done       = fetch_done_q;
  assign busy             = busy_q;
  assign cache_hit        = cache_hit_q;

endmodule
